counting_tx: RTL and testbench
==============================

Name: counting_tx

Overview:
- Transmit side of the 2-bit symbol stream consumed by the pattern-counting detector.
- Accepts 16-bit words through a valid/ready handshake, buffers them in a small FIFO, and serializes each word into eight 2-bit symbols on `num`, one per clock, MSB pair first.
- A shadow copy of the detector FSM runs on the emitted stream, so the sender knows when the trigger has been delivered.

Parameters:
- DEPTH, 4: word FIFO depth; power of two, at least 2.
- IDLE_SYM, 2'b00: symbol driven on `num` when no word is being sent.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_word  input  16  word to transmit; symbol k = in_word[15-2k:14-2k], k=0..7.
- in_valid  input  1  in_word valid.
- in_ready  output  1  FIFO can accept a word; equals !full.
- num  output  2  registered symbol stream.
- num_valid  output  1  num carries a data symbol (0 when IDLE_SYM filler).
- busy  output  1  FIFO non-empty or symbols remaining.
- hit  output  1  shadow detector in S3.
- frames_sent  output  8  count of completed words, wraps 255->0.

Behaviour:
- Reset values (after the reset edge): FIFO empty, in_ready=1, num=IDLE_SYM, num_valid=0, busy=0, hit=0, frames_sent=0, rem=0, shadow state S0.
- Reset mid-frame abandons the current word and all queued words. No partial-frame count.
- Push: a word is written on an edge where in_valid && in_ready.
  - Push is refused when full, even if a pop happens on the same edge.
  - Push and pop on the same edge are allowed when not full; count is unchanged.
- Serializer, with rem = symbols of the current word still to emit. On each edge:
  - rem>0: num<=shreg[15:14], shreg<<=2, rem<=rem-1, num_valid<=1.
  - else if FIFO non-empty: pop word w, num<=w[15:14], shreg<=w<<2, rem<=7, num_valid<=1.
  - else: num<=IDLE_SYM, num_valid<=0.
- Latency: a word pushed into an empty, idle block appears as its first symbol on the edge immediately after the push edge.
- Back-to-back words produce a contiguous stream with no idle gap. Each word gives exactly 8 symbols.
- frames_sent increments on the edge that loads a word's 8th symbol into num.
- Shadow detector:
  - Advances on every edge using the current num value, including idle filler, because the receiver samples every cycle.
  - Transitions:
    - S0: 01->S1, else S0.
    - S1: 00->S1, 01->S1, 10->S2, 11->S0.
    - S2: 00->S2, 01->S1, 10->S0, 11->S3.
    - S3: sticky in S3 until reset.
  - hit = (state==S3), registered, so it rises one edge after the closing 11 symbol.
- busy = (count!=0) || (rem!=0) || num_valid.
- FIFO pointers are log2(DEPTH) bits wide, wrapping modulo DEPTH. Count is log2(DEPTH)+1 bits wide.

Test Plan:
1. Reset, push 0x6C00 once -> num 01,10,11,00,00,00,00,00 with num_valid=1 for 8 cycles, then IDLE with num_valid=0; hit=1 from the edge after symbol 11 and stays 1; frames_sent=1.
2. Push 0x7000 (01,11,00...) -> hit stays 0 for 20 cycles; frames_sent=1.
3. Push 0x4000 then 0x8000, then 0xC000 (sequence 01,00..,10,00..,11,00..) -> hit=1 only after the third word's first symbol; frames_sent=3; 24 contiguous valid symbols.
4. DEPTH=4, in_valid held high with 6 distinct words -> in_ready drops while 4 words are queued; every word is emitted in order with no loss or duplication; 48 contiguous valid symbols; frames_sent=6; busy falls one cycle after the last symbol.
5. Assert reset at symbol 4 of a word, with 2 words queued -> next cycle num=00, num_valid=0, in_ready=1, hit=0, frames_sent=0; no queued word is emitted afterwards.
6. Push 256 words (0x0000) -> frames_sent wraps to 0; hit stays 0.

Source files
------------

// File: rtl/counting_tx.sv
// Word-to-symbol transmitter: buffers 16-bit words, emits eight 2-bit symbols per word,
// and tracks the receiver's pattern detector on the emitted stream.
module counting_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module counting_tx #(
  parameter int         DEPTH    = 4,
  parameter logic [1:0] IDLE_SYM = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [1:0]  num,
  output logic        num_valid,
  output logic        busy,
  output logic        hit,
  output logic [7:0]  frames_sent
);
  typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

  logic        full, empty, push, pop;
  logic [15:0] head;
  logic [15:0] shreg;
  logic [2:0]  rem;
  state_t      state, state_nxt;

  // A full FIFO refuses a push even when the serializer pops on the same edge.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (rem == 3'd0) && !empty;
  assign busy     = !empty || (rem != 3'd0) || num_valid;

  counting_tx_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_word),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= '0;
      rem         <= '0;
      num         <= IDLE_SYM;
      num_valid   <= 1'b0;
      frames_sent <= '0;
    end else if (rem != 3'd0) begin
      num       <= shreg[15:14];
      shreg     <= shreg << 2;
      rem       <= rem - 3'd1;
      num_valid <= 1'b1;
      // rem==1 means this edge loads the word's last symbol.
      if (rem == 3'd1) frames_sent <= frames_sent + 8'd1;
    end else if (pop) begin
      num       <= head[15:14];
      shreg     <= head << 2;
      rem       <= 3'd7;
      num_valid <= 1'b1;
    end else begin
      num       <= IDLE_SYM;
      num_valid <= 1'b0;
    end
  end

  // Shadow detector sees every cycle's num, filler included, like the receiver.
  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S0: state_nxt = (num == 2'b01) ? S1 : S0;
      S1: case (num)
            2'b10:   state_nxt = S2;
            2'b11:   state_nxt = S0;
            default: state_nxt = S1;
          endcase
      S2: case (num)
            2'b01:   state_nxt = S1;
            2'b10:   state_nxt = S0;
            2'b11:   state_nxt = S3;
            default: state_nxt = S2;
          endcase
      default: state_nxt = S3;
    endcase
  end

  always_comb begin
    hit = (state == S3);
  end
endmodule

// File: tb/tb_counting_tx.sv
// Directed bench for counting_tx: per-cycle vector table plus streamed multi-word sequences.
module tb_counting_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  num;
  logic        num_valid;
  logic        busy;
  logic        hit;
  logic [7:0]  frames_sent;

  int total = 0;
  int bad   = 0;

  counting_tx #(.DEPTH(4), .IDLE_SYM(2'b00)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .num         (num),
    .num_valid   (num_valid),
    .busy        (busy),
    .hit         (hit),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] w;
    logic [1:0]  e_num;
    logic        e_nv;
    logic        e_rdy;
    logic        e_busy;
    logic        e_hit;
    logic [7:0]  e_fs;
  } vec_t;

  vec_t tbl [11];

  logic [15:0] words [$];
  int s_num [$];
  int s_nv [$];
  int s_hit [$];
  int s_busy [$];
  int s_rdy [$];
  int s_fs [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_word = '0;
    tick();
    reset = 1'b0;
  endtask

  // Offer words[] with in_valid held high; record every cycle until drained.
  task automatic run_stream(input int max_cyc);
    int idx = 0;
    int cyc = 0;
    logic rdy_before;
    s_num.delete(); s_nv.delete(); s_hit.delete();
    s_busy.delete(); s_rdy.delete(); s_fs.delete();
    while (1) begin
      in_valid   = (idx < words.size());
      in_word    = (idx < words.size()) ? words[idx] : 16'h0;
      rdy_before = in_ready;
      tick();
      if (in_valid && rdy_before) idx++;
      s_num.push_back(num); s_nv.push_back(num_valid); s_hit.push_back(hit);
      s_busy.push_back(busy); s_rdy.push_back(in_ready); s_fs.push_back(frames_sent);
      cyc++;
      if (idx == words.size() && !busy) break;
      if (cyc >= max_cyc) begin
        chk("stream_timeout", cyc, -1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Check that the valid samples form one contiguous run equal to words[] serialized.
  task automatic chk_symbols(input string name);
    int first = -1;
    int nvcnt = 0;
    int gaps  = 0;
    int errs  = 0;
    int k;
    for (int i = 0; i < s_nv.size(); i++) if (s_nv[i] == 1 && first < 0) first = i;
    for (int i = 0; i < s_nv.size(); i++) nvcnt += s_nv[i];
    chk({name, "_nvcount"}, nvcnt, 8 * words.size());
    if (first < 0) first = 0;
    for (int i = first; i < first + nvcnt && i < s_nv.size(); i++) if (s_nv[i] != 1) gaps++;
    chk({name, "_gaps"}, gaps, 0);
    k = 0;
    for (int i = first; i < s_nv.size() && k < 8 * words.size(); i++) begin
      logic [15:0] w;
      w = words[k / 8];
      if (s_num[i] != int'((w >> (14 - 2 * (k % 8))) & 16'h3)) errs++;
      k++;
    end
    chk({name, "_symbols"}, errs, 0);
  endtask

  initial begin
    int first;
    int hits;
    int minrdy;
    int nvs;
    int busy_err;

    // Single 0x6C00 word from reset, cycle by cycle (rst vld w num nv rdy busy hit fs).
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h6C00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1};

    reset = 1'b1; in_valid = 1'b0; in_word = '0;
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; in_valid = tbl[i].vld; in_word = tbl[i].w;
      tick();
      chk($sformatf("t1_num_%0d", i),  num,         tbl[i].e_num);
      chk($sformatf("t1_nv_%0d", i),   num_valid,   tbl[i].e_nv);
      chk($sformatf("t1_rdy_%0d", i),  in_ready,    tbl[i].e_rdy);
      chk($sformatf("t1_busy_%0d", i), busy,        tbl[i].e_busy);
      chk($sformatf("t1_hit_%0d", i),  hit,         tbl[i].e_hit);
      chk($sformatf("t1_fs_%0d", i),   frames_sent, tbl[i].e_fs);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_hit_sticky", hit, 1);

    // 01,11 never reaches S3.
    do_reset();
    words = '{16'h7000};
    run_stream(50);
    chk_symbols("t2");
    hits = 0;
    for (int i = 0; i < 20; i++) begin tick(); hits += hit; end
    for (int i = 0; i < s_hit.size(); i++) hits += s_hit[i];
    chk("t2_hits", hits, 0);
    chk("t2_fs", frames_sent, 1);

    // 01 / 10 / 11 spread over three words, closing 11 opens the third word.
    do_reset();
    words = '{16'h4000, 16'h8000, 16'hC000};
    run_stream(100);
    chk_symbols("t3");
    first = -1;
    for (int i = 0; i < s_nv.size(); i++) if (s_nv[i] == 1 && first < 0) first = i;
    if (first < 0) first = 0;
    hits = 0;
    for (int i = 0; i <= first + 16 && i < s_hit.size(); i++) hits += s_hit[i];
    chk("t3_hit_early", hits, 0);
    chk("t3_sym11", (first + 16 < s_num.size()) ? s_num[first + 16] : -1, 3);
    chk("t3_hit_rise", (first + 17 < s_hit.size()) ? s_hit[first + 17] : -1, 1);
    chk("t3_fs", frames_sent, 3);

    // Six words with in_valid held: back-pressure, ordering, busy fall.
    do_reset();
    words = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hA5A5};
    run_stream(200);
    chk_symbols("t4");
    minrdy = 1;
    for (int i = 0; i < s_rdy.size(); i++) if (s_rdy[i] == 0) minrdy = 0;
    chk("t4_rdy_dropped", minrdy, 0);
    chk("t4_fs", frames_sent, 6);
    busy_err = 0;
    for (int i = 1; i < s_nv.size(); i++)
      if (s_nv[i - 1] == 1 && s_nv[i] == 0 && s_busy[i] != 0) busy_err++;
    if (s_nv.size() > 1 && s_busy[s_busy.size() - 2] != 1) busy_err++;
    chk("t4_busy_fall", busy_err, 0);

    // Reset mid-word with two words queued.
    do_reset();
    in_valid = 1'b1;
    in_word = 16'h6C00; tick();
    in_word = 16'h1111; tick();
    in_word = 16'h2222; tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t5_pre_num", num, 0);
    chk("t5_pre_nv", num_valid, 1);
    chk("t5_pre_hit", hit, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_num", num, 0);
    chk("t5_nv", num_valid, 0);
    chk("t5_rdy", in_ready, 1);
    chk("t5_hit", hit, 0);
    chk("t5_fs", frames_sent, 0);
    chk("t5_busy", busy, 0);
    nvs = 0;
    for (int i = 0; i < 20; i++) begin tick(); nvs += num_valid + busy; end
    chk("t5_no_replay", nvs, 0);

    // 256 zero words wrap the frame counter.
    do_reset();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(16'h0000);
    run_stream(3000);
    nvs = 0; hits = 0;
    for (int i = 0; i < s_nv.size(); i++) begin nvs += s_nv[i]; hits += s_hit[i]; end
    chk("t6_nv", nvs, 2048);
    chk("t6_hits", hits, 0);
    chk("t6_fs_255_seen", (s_fs.size() > 2) ? s_fs[s_fs.size() - 3] : -1, 255);
    chk("t6_fs_wrap", frames_sent, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
